mem_miss_handler: RTL

- Downstream of the processor's instruction and data caches; services cache misses against the unified multi-cycle main memory.
- Arbitrates between an I-cache miss and a D-cache miss, then issues 8 word reads for one 16-byte block.
- Streams the returned words into the selected cache's data array, then commits the tag.
- Drives the global stall while a fill is pending or active.

---
 rtl/mem_miss_handler_pkg.sv | 11 +
 rtl/mem_miss_handler_fill_counter.sv | 18 +
 rtl/mem_miss_handler.sv | 90 +++++++++
 3 files changed

// File: rtl/mem_miss_handler_pkg.sv
// mem_miss_handler_pkg: shared types and constants for the cache miss handler
package mem_miss_handler_pkg;
    localparam int ADDR_W          = 16;
    localparam int WORDS_PER_BLOCK = 8;
    localparam int BLK_OFF_W       = 4;
    localparam int WORD_IDX_W      = $clog2(WORDS_PER_BLOCK);
    localparam int BLK_W           = ADDR_W - BLK_OFF_W;
    localparam logic TGT_I = 1'b0;
    localparam logic TGT_D = 1'b1;
    typedef enum logic [1:0] {IDLE, FILL, COMMIT} state_t;
endpackage

// File: rtl/mem_miss_handler_fill_counter.sv
// fill_counter: word index counter with clear, enable and terminal count
import mem_miss_handler_pkg::*;

module fill_counter (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  en,
    output logic [WORD_IDX_W-1:0] cnt,
    output logic                  tc
);
    // clear has priority over counting; wraps naturally after the last word
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en) cnt <= cnt + 1'b1;
    assign tc = &cnt;
endmodule

// File: rtl/mem_miss_handler.sv
// mem_miss_handler: arbitrates I/D cache misses and fills one block from main memory
import mem_miss_handler_pkg::*;

module mem_miss_handler (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  imiss_req,
    input  logic [ADDR_W-1:0]     imiss_addr,
    input  logic                  dmiss_req,
    input  logic [ADDR_W-1:0]     dmiss_addr,
    output logic                  mem_en,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic                  mem_data_valid,
    input  logic [15:0]           mem_data,
    output logic                  fill_we,
    output logic                  fill_tgt,
    output logic [WORD_IDX_W-1:0] fill_word,
    output logic [15:0]           fill_data,
    output logic [BLK_W-1:0]      fill_blk,
    output logic                  tag_we,
    output logic                  fill_done_i,
    output logic                  fill_done_d,
    output logic                  stall
);
    state_t                state;
    logic                  issue_done;
    logic [WORD_IDX_W-1:0] issue_cnt, recv_cnt;
    logic                  issue_tc, recv_tc;
    logic                  unused_offsets;

    assign unused_offsets = ^{imiss_addr[BLK_OFF_W-1:0], dmiss_addr[BLK_OFF_W-1:0]};

    assign mem_en    = (state == FILL) && !issue_done;
    assign mem_addr  = {fill_blk, issue_cnt, 1'b0};
    assign fill_we   = (state == FILL) && mem_data_valid;
    assign fill_word = recv_cnt;
    assign fill_data = mem_data;
    assign stall     = (state != IDLE) || imiss_req || dmiss_req;

    fill_counter u_issue_cnt (
        .clk(clk), .rst_n(rst_n), .clr(state == IDLE), .en(mem_en),
        .cnt(issue_cnt), .tc(issue_tc)
    );

    fill_counter u_recv_cnt (
        .clk(clk), .rst_n(rst_n), .clr(state == IDLE), .en(fill_we),
        .cnt(recv_cnt), .tc(recv_tc)
    );

    // control FSM: D wins arbitration, issue stops after the last word, commit on the last return
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            fill_blk    <= '0;
            fill_tgt    <= TGT_I;
            issue_done  <= 1'b0;
            tag_we      <= 1'b0;
            fill_done_i <= 1'b0;
            fill_done_d <= 1'b0;
        end else begin
            tag_we      <= 1'b0;
            fill_done_i <= 1'b0;
            fill_done_d <= 1'b0;
            case (state)
                IDLE: begin
                    issue_done <= 1'b0;
                    if (dmiss_req) begin
                        fill_blk <= dmiss_addr[ADDR_W-1:BLK_OFF_W];
                        fill_tgt <= TGT_D;
                        state    <= FILL;
                    end else if (imiss_req) begin
                        fill_blk <= imiss_addr[ADDR_W-1:BLK_OFF_W];
                        fill_tgt <= TGT_I;
                        state    <= FILL;
                    end
                end
                FILL: begin
                    if (mem_en && issue_tc) issue_done <= 1'b1;
                    if (fill_we && recv_tc) begin
                        state       <= COMMIT;
                        tag_we      <= 1'b1;
                        fill_done_i <= (fill_tgt == TGT_I);
                        fill_done_d <= (fill_tgt == TGT_D);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
